// File: rtl/vx_vector_repack.sv
`default_nettype none
// ============================================================================
//  Module   : vx_vector_repack
//  Purpose  : Collects BEATS narrow ALU result beats into a single wide vector
//             register write, with a per-lane write mask.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef VLEN_ARCH
`define VLEN_ARCH 256
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif

module vx_vector_repack #(
    parameter int VLEN        = `VLEN_ARCH,
    parameter int XLEN        = `XLEN,
    parameter int NUM_THREADS = `NUM_THREADS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [NUM_THREADS*XLEN-1:0]   data_in,
    input  logic [NUM_THREADS-1:0]        tmask_in,
    input  logic [`NW_WIDTH-1:0]          wid_in,
    input  logic [4:0]                    rd_in,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic [VLEN-1:0]               vd_data_out,
    output logic [VLEN/XLEN-1:0]          vd_mask_out,
    output logic [`NW_WIDTH-1:0]          wid_out,
    output logic [4:0]                    rd_out,
    output logic                          err_out
);

    localparam int LANES   = VLEN / XLEN;
    localparam int BEATS   = LANES / NUM_THREADS;
    localparam int c_cnt_w = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    generate
        if (BEATS < 1 || (VLEN % XLEN) != 0 || (LANES % NUM_THREADS) != 0) begin : g_bad_cfg
            $error("vx_vector_repack: VLEN/XLEN/NUM_THREADS do not divide into whole beats");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [VLEN-1:0]       r_vd_data;
    logic [LANES-1:0]      r_vd_mask;
    logic [`NW_WIDTH-1:0]  r_wid;
    logic [4:0]            r_rd;
    logic                  r_err;

    logic                  w_accept;
    logic [c_cnt_w-1:0]    w_beat;
    logic [VLEN-1:0]       w_data_nxt;
    logic [LANES-1:0]      w_mask_nxt;

    assign ready_out = (r_state != S_FULL);
    assign valid_out = (r_state == S_FULL);
    assign w_accept  = valid_in && ready_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (BEATS == 1) ? S_FULL : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept && (r_cnt == c_last_beat)) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (ready_in) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new group starts from a cleared vector so lanes never written read 0.
    always_comb begin
        w_beat     = (r_state == S_IDLE) ? '0 : r_cnt;
        w_data_nxt = (r_state == S_IDLE) ? '0 : r_vd_data;
        w_mask_nxt = (r_state == S_IDLE) ? '0 : r_vd_mask;
        for (int l = 0; l < LANES; l++) begin
            if ((l / NUM_THREADS) == int'(w_beat)) begin
                w_mask_nxt[l] = tmask_in[l % NUM_THREADS];
                w_data_nxt[l*XLEN +: XLEN] = tmask_in[l % NUM_THREADS]
                    ? data_in[(l % NUM_THREADS)*XLEN +: XLEN] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_vd_data <= '0;
            r_vd_mask <= '0;
            r_wid     <= '0;
            r_rd      <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_vd_data <= w_data_nxt;
            r_vd_mask <= w_mask_nxt;
            if (r_state == S_IDLE) begin
                r_wid <= wid_in;
                r_rd  <= rd_in;
                r_cnt <= (BEATS == 1) ? '0 : c_one;
            end else begin
                // Mismatched beats are still written; the flag is sticky until reset.
                if ((wid_in != r_wid) || (rd_in != r_rd)) begin
                    r_err <= 1'b1;
                end
                r_cnt <= (r_cnt == c_last_beat) ? '0 : (r_cnt + c_one);
            end
        end
    end

    assign vd_data_out = r_vd_data;
    assign vd_mask_out = r_vd_mask;
    assign wid_out     = r_wid;
    assign rd_out      = r_rd;
    assign err_out     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vx_vector_repack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_vector_repack
//  Purpose  : Directed self-checking bench for vx_vector_repack (LANES=8, BEATS=2).
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif

module tb_vx_vector_repack;

    localparam int c_xlen = 32;
    localparam int c_nt   = 4;
    localparam int c_nw   = `NW_WIDTH;

    typedef struct packed {
        logic [255:0]    data;
        logic [7:0]      mask;
        logic [c_nw-1:0] wid;
        logic [4:0]      rd;
    } grp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic              ready_out;
    logic [127:0]      data_in;
    logic [3:0]        tmask_in;
    logic [c_nw-1:0]   wid_in;
    logic [4:0]        rd_in;
    logic              valid_out;
    logic              ready_in;
    logic [255:0]      vd_data_out;
    logic [7:0]        vd_mask_out;
    logic [c_nw-1:0]   wid_out;
    logic [4:0]        rd_out;
    logic              err_out;

    grp_t r_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vx_vector_repack #(.VLEN(256), .XLEN(32), .NUM_THREADS(4)) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_out(ready_out),
        .data_in(data_in), .tmask_in(tmask_in), .wid_in(wid_in), .rd_in(rd_in),
        .valid_out(valid_out), .ready_in(ready_in),
        .vd_data_out(vd_data_out), .vd_mask_out(vd_mask_out),
        .wid_out(wid_out), .rd_out(rd_out), .err_out(err_out)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vector: beat b, thread t lands in lane b*4+t; masked lanes stay 0.
    function automatic grp_t mk_group(input logic [127:0] d0, input logic [3:0] m0,
                                      input logic [127:0] d1, input logic [3:0] m1,
                                      input logic [c_nw-1:0] w, input logic [4:0] r);
        grp_t g;
        logic [127:0] d;
        logic [3:0]   m;
        g.data = '0;
        g.mask = '0;
        g.wid  = w;
        g.rd   = r;
        for (int b = 0; b < 2; b++) begin
            d = (b == 0) ? d0 : d1;
            m = (b == 0) ? m0 : m1;
            for (int t = 0; t < c_nt; t++) begin
                if (m[t]) begin
                    g.data[(b*c_nt+t)*c_xlen +: c_xlen] = d[t*c_xlen +: c_xlen];
                    g.mask[b*c_nt+t] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [127:0] tp_data(input int k);
        logic [127:0] d;
        for (int t = 0; t < c_nt; t++) begin
            d[t*c_xlen +: c_xlen] = 32'h3000 + 32'(k*16 + t);
        end
        return d;
    endfunction

    task automatic beat(input logic [127:0] d, input logic [3:0] m,
                        input logic [c_nw-1:0] w, input logic [4:0] r);
        valid_in = 1'b1;
        data_in  = d;
        tmask_in = m;
        wid_in   = w;
        rd_in    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_group(input logic [127:0] d0, input logic [3:0] m0,
                              input logic [127:0] d1, input logic [3:0] m1,
                              input logic [c_nw-1:0] w0, input logic [c_nw-1:0] w1,
                              input logic [4:0] r);
        r_q.push_back(mk_group(d0, m0, d1, m1, w0, r));
        beat(d0, m0, w0, r);
        beat(d1, m1, w1, r);
        valid_in = 1'b0;
    endtask

    task automatic check_out(input string tag);
        grp_t g;
        chk({tag, "_sb_nonempty"}, r_q.size() != 0, 1'b1);
        if (r_q.size() != 0) begin
            g = r_q[0];
            chk({tag, "_data"}, vd_data_out, g.data);
            chk({tag, "_mask"}, vd_mask_out, g.mask);
            chk({tag, "_wid"},  wid_out,     g.wid);
            chk({tag, "_rd"},   rd_out,      g.rd);
        end
    endtask

    // Called right after the last beat's edge; ready_in must already be 1.
    task automatic drain_check(input string tag);
        @(negedge clk);
        chk({tag, "_valid_lat"}, valid_out, 1'b1);
        chk({tag, "_ready_full"}, ready_out, 1'b0);
        check_out(tag);
        if (r_q.size() != 0) void'(r_q.pop_front());
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, "_valid_one"}, valid_out, 1'b0);
    endtask

    initial begin
        logic acc;
        int   k;

        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        tmask_in = '0;
        wid_in   = '0;
        rd_in    = '0;
        ready_in = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_err",   err_out,   1'b0);
        chk("rst_data",  vd_data_out, 256'h0);
        chk("rst_mask",  vd_mask_out, 8'h0);
        chk("rst_wid",   wid_out, 2'h0);
        chk("rst_rd",    rd_out,  5'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);

        // Basic full group.
        send_group(128'h00000014_00000013_00000012_00000011, 4'hF,
                   128'h00000024_00000023_00000022_00000021, 4'hF, 0, 0, 5'd3);
        drain_check("t1");
        chk("t1_lanes", vd_data_out,
            256'h00000024_00000023_00000022_00000021_00000014_00000013_00000012_00000011);
        chk("t1_mask_ff", vd_mask_out, 8'hFF);

        // Backpressure: hold FULL for 5 cycles with a stray beat offered.
        ready_in = 1'b0;
        send_group(128'h00000044_00000043_00000042_00000041, 4'hF,
                   128'h00000054_00000053_00000052_00000051, 4'hF, 1, 1, 5'd4);
        valid_in = 1'b1;
        data_in  = {4{32'hDEADBEEF}};
        tmask_in = 4'hF;
        wid_in   = 2'd3;
        rd_in    = 5'd31;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t2_hold_valid%0d", i), valid_out, 1'b1);
            chk($sformatf("t2_hold_ready%0d", i), ready_out, 1'b0);
            check_out($sformatf("t2_hold%0d", i));
        end
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        if (r_q.size() != 0) void'(r_q.pop_front());
        @(negedge clk);
        chk("t2_released", valid_out, 1'b0);
        chk("t2_ready_idle", ready_out, 1'b1);

        // A fully masked beat still counts.
        send_group(128'h00000064_00000063_00000062_00000061, 4'h0,
                   128'h00000074_00000073_00000072_00000071, 4'hF, 0, 0, 5'd5);
        drain_check("t2b");

        // Sparse masks.
        send_group(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 4'h5,
                   128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 4'hA, 0, 0, 5'd6);
        drain_check("t3");
        chk("t3_mask_a5", vd_mask_out, 8'hA5);
        chk("t3_lanes", vd_data_out,
            256'hB3B3B3B3_00000000_B1B1B1B1_00000000_00000000_A2A2A2A2_00000000_A0A0A0A0);

        // Warp id mismatch sets the sticky error.
        send_group(128'h1, 4'hF, 128'h2, 4'hF, 1, 2, 5'd2);
        drain_check("t4");
        chk("t4_err_set", err_out, 1'b1);
        send_group(128'h3, 4'hF, 128'h4, 4'hF, 3, 3, 5'd3);
        drain_check("t4_good");
        chk("t4_err_sticky", err_out, 1'b1);

        // Reset mid-group discards the partial group.
        beat(128'hFFFF, 4'hF, 2, 5'd9);
        valid_in = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        chk("t5_rst_err",   err_out, 1'b0);
        chk("t5_rst_valid", valid_out, 1'b0);
        chk("t5_rst_ready", ready_out, 1'b1);
        chk("t5_rst_mask",  vd_mask_out, 8'h0);
        chk("t5_rst_rd",    rd_out, 5'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_group(128'h00000084_00000083_00000082_00000081, 4'h3,
                   128'h00000094_00000093_00000092_00000091, 4'hC, 1, 1, 5'd8);
        drain_check("t5");
        chk("t5_err_clear", err_out, 1'b0);

        // Continuous streaming: accept, accept, stall.
        for (int g = 0; g < 3; g++) begin
            r_q.push_back(mk_group(tp_data(2*g), 4'hF, tp_data(2*g+1), 4'hF, 0, 5'(10 + g)));
        end
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            valid_in = 1'b1;
            data_in  = tp_data(k);
            tmask_in = 4'hF;
            wid_in   = 2'd0;
            rd_in    = 5'(10 + k/2);
            @(negedge clk);
            chk($sformatf("tp_ready%0d", cyc), ready_out, (cyc % 3) != 2);
            chk($sformatf("tp_valid%0d", cyc), valid_out, (cyc % 3) == 2);
            if (valid_out) begin
                check_out($sformatf("tp%0d", cyc));
                if (r_q.size() != 0) void'(r_q.pop_front());
            end
            acc = ready_out;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        valid_in = 1'b0;
        chk("tp_beats", k, 6);
        chk("sb_drained", r_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
